// File: rtl/neuron_flit_bridge_if.sv
// Signal bundle between neuron_flit_bridge and its neuron core / router neighbours.
// slave = bridge side; master = core + router side.
interface neuron_flit_bridge_if #(
  parameter int PACKET_WIDTH       = 32,
  parameter int FLIT_WIDTH         = 4,
  parameter int AXON_CNT_BIT_WIDTH = 1
);
  localparam int SPIKE_W = 1 << AXON_CNT_BIT_WIDTH;

  logic                    start;
  logic [PACKET_WIDTH-1:0] pkt_in;
  logic                    pkt_wr;
  logic                    pkt_full;
  logic                    pkt_drop;
  logic [FLIT_WIDTH-1:0]   flit_out;
  logic                    flit_wr;
  logic                    rt_full;
  logic [FLIT_WIDTH-1:0]   flit_in;
  logic                    flit_in_wr;
  logic                    neuron_full;
  logic [SPIKE_W-1:0]      spike;
  logic                    rx_misroute;

  modport slave (
    input  start, pkt_in, pkt_wr, rt_full, flit_in, flit_in_wr,
    output pkt_full, pkt_drop, flit_out, flit_wr, neuron_full, spike, rx_misroute
  );

  modport master (
    output start, pkt_in, pkt_wr, rt_full, flit_in, flit_in_wr,
    input  pkt_full, pkt_drop, flit_out, flit_wr, neuron_full, spike, rx_misroute
  );
endinterface

// File: rtl/neuron_flit_bridge.sv
// Neuron-to-router bridge: TX packet FIFO + flit serialiser, RX deserialiser, double-buffered spikes.
// Optional macro LOCAL_PACKET_BYPASS_EN: self-addressed TX packets set spikes directly, emitting no flits.
module neuron_flit_bridge #(
  parameter int PACKET_WIDTH       = 32,
  parameter int FLIT_WIDTH         = 4,
  parameter int TX_DEPTH           = 4,
  parameter int ADDR_WIDTH         = 8,
  parameter int AXON_CNT_BIT_WIDTH = 1,
  parameter int X_COORDINATE       = 0,
  parameter int Y_COORDINATE       = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  neuron_flit_bridge_if.slave bus
);

  localparam int NF      = PACKET_WIDTH / FLIT_WIDTH;
  localparam int IDX_W   = (NF > 1) ? $clog2(NF) : 1;
  localparam int PTR_W   = $clog2(TX_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SPIKE_W = 1 << AXON_CNT_BIT_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] MY_X     = ADDR_WIDTH'(X_COORDINATE);
  localparam logic [ADDR_WIDTH-1:0] MY_Y     = ADDR_WIDTH'(Y_COORDINATE);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NF - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(TX_DEPTH);

  typedef logic [PACKET_WIDTH-1:0] pkt_t;
  typedef logic [SPIKE_W-1:0]      spike_t;
  typedef enum logic { IDLE, SEND } tx_state_t;

  function automatic logic is_local(input pkt_t p);
    return (p[PACKET_WIDTH-1 -: ADDR_WIDTH] == MY_X) &&
           (p[PACKET_WIDTH-ADDR_WIDTH-1 -: ADDR_WIDTH] == MY_Y);
  endfunction

  function automatic spike_t axon_onehot(input pkt_t p);
    spike_t v;
    v = '0;
    v[p[AXON_CNT_BIT_WIDTH-1:0]] = 1'b1;
    return v;
  endfunction

  // ---------------------------------------------------------------- TX FIFO
  pkt_t             fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt, cnt_next;
  logic             full_q, drop_q;
  logic             push, pop, fifo_empty;
  pkt_t             fifo_head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  // A push while full is refused even if a pop frees a slot this cycle.
  assign push       = bus.pkt_wr && !full_q;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_next = fifo_cnt;
    case ({push, pop})
      2'b10:   cnt_next = fifo_cnt + 1'b1;
      2'b01:   cnt_next = fifo_cnt - 1'b1;
      default: cnt_next = fifo_cnt;
    endcase
  end

  // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.pkt_in;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= cnt_next;
      full_q   <= (cnt_next == FULL_CNT);
      drop_q   <= bus.pkt_wr && full_q;
    end
  end

  // ---------------------------------------------------------------- TX serialiser
  tx_state_t        state_q, state_d;
  pkt_t             tx_sr;
  logic [IDX_W-1:0] flit_idx;
  logic             take, load, flit_wr;
  spike_t           byp_set;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    flit_wr = 1'b0;
    byp_set = '0;
    unique case (state_q)
      IDLE: take = !fifo_empty;
      SEND: begin
        flit_wr = !bus.rt_full;
        if (flit_wr && (flit_idx == LAST_IDX)) begin
          state_d = IDLE;
          take    = !fifo_empty;
        end
      end
    endcase
    if (take) begin
      pop     = 1'b1;
      load    = 1'b1;
      state_d = SEND;
`ifdef LOCAL_PACKET_BYPASS_EN
      // Self-addressed packets never reach the router; their spike lands on the pop edge.
      if (is_local(fifo_head)) begin
        load    = 1'b0;
        state_d = IDLE;
        byp_set = axon_onehot(fifo_head);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_sr    <= '0;
      flit_idx <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        tx_sr    <= fifo_head;
        flit_idx <= '0;
      end else if (flit_wr) begin
        tx_sr    <= tx_sr << FLIT_WIDTH;
        flit_idx <= flit_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX deserialiser
  logic [PACKET_WIDTH-FLIT_WIDTH-1:0] rx_sr;
  pkt_t                               rx_pkt;
  logic [IDX_W-1:0]                   rx_cnt;
  logic                               rx_done, misroute_q;
  spike_t                             rx_set;

  assign rx_pkt  = {rx_sr, bus.flit_in};
  assign rx_done = bus.flit_in_wr && (rx_cnt == LAST_IDX);
  assign rx_set  = (rx_done && is_local(rx_pkt)) ? axon_onehot(rx_pkt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr      <= '0;
      rx_cnt     <= '0;
      misroute_q <= 1'b0;
    end else begin
      if (bus.flit_in_wr) begin
        rx_sr  <= rx_pkt[PACKET_WIDTH-FLIT_WIDTH-1:0];
        rx_cnt <= rx_done ? '0 : rx_cnt + 1'b1;
      end
      misroute_q <= rx_done && !is_local(rx_pkt);
    end
  end

  // ---------------------------------------------------------------- spike double buffer
  spike_t spike_acc, spike_q, set_vec;

  assign set_vec = rx_set | byp_set;

  // Bits set on a start edge belong to the timestep that begins there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_acc <= '0;
      spike_q   <= '0;
    end else if (bus.start) begin
      spike_q   <= spike_acc;
      spike_acc <= set_vec;
    end else begin
      spike_acc <= spike_acc | set_vec;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.pkt_full    = full_q;
  assign bus.pkt_drop    = drop_q;
  assign bus.flit_wr     = flit_wr;
  assign bus.flit_out    = (state_q == SEND) ? tx_sr[PACKET_WIDTH-1 -: FLIT_WIDTH] : '0;
  assign bus.neuron_full = 1'b0;
  assign bus.spike       = spike_q;
  assign bus.rx_misroute = misroute_q;

endmodule

// File: tb/tb_neuron_flit_bridge.sv
// Directed bench for neuron_flit_bridge (default parameters); TX flits are checked against a scoreboard queue.
module tb_neuron_flit_bridge;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  neuron_flit_bridge_if #(.PACKET_WIDTH(32), .FLIT_WIDTH(4), .AXON_CNT_BIT_WIDTH(1)) bus ();

  neuron_flit_bridge #(
    .PACKET_WIDTH(32), .FLIT_WIDTH(4), .TX_DEPTH(4), .ADDR_WIDTH(8),
    .AXON_CNT_BIT_WIDTH(1), .X_COORDINATE(0), .Y_COORDINATE(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;
  logic [3:0] sb [$];
  logic [3:0] exp_flit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected flits of one pushed packet, MSB flit first; local packets vanish when bypass is built in.
  task automatic sb_push_pkt(input logic [31:0] p);
`ifdef LOCAL_PACKET_BYPASS_EN
    if (p[31:24] == 8'd0 && p[23:16] == 8'd0) return;
`endif
    for (int i = 0; i < 8; i++) sb.push_back(p[31-4*i -: 4]);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic send_rx(input logic [31:0] p, input bit start_last);
    for (int i = 0; i < 8; i++) begin
      bus.flit_in_wr = 1'b1;
      bus.flit_in    = p[31-4*i -: 4];
      bus.start      = start_last && (i == 7);
      tick();
    end
    bus.flit_in_wr = 1'b0;
    bus.flit_in    = '0;
    bus.start      = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flit_wr"},     bus.flit_wr,     0);
    check({tag, "_flit_out"},    bus.flit_out,    0);
    check({tag, "_pkt_full"},    bus.pkt_full,    0);
    check({tag, "_pkt_drop"},    bus.pkt_drop,    0);
    check({tag, "_neuron_full"}, bus.neuron_full, 0);
    check({tag, "_spike"},       bus.spike,       0);
    check({tag, "_rx_misroute"}, bus.rx_misroute, 0);
  endtask

  // Scoreboard monitor: every emitted flit must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && bus.flit_wr) begin
      if (sb.size() == 0) check("unexpected_flit", {28'd0, bus.flit_out}, 32'hdead);
      else begin
        exp_flit = sb.pop_front();
        check("flit", bus.flit_out, exp_flit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.pkt_in     = '0;
    bus.pkt_wr     = 1'b0;
    bus.rt_full    = 1'b0;
    bus.flit_in    = '0;
    bus.flit_in_wr = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Basic serialisation and first-flit latency.
    bus.pkt_in = 32'h0102_0001;
    bus.pkt_wr = 1'b1;
    sb_push_pkt(32'h0102_0001);
    tick();
    bus.pkt_wr = 1'b0;
    @(negedge clk);
    check("lat_c1_flit_wr", bus.flit_wr, 0);
    tick();
    @(negedge clk);
    check("lat_c2_flit_wr", bus.flit_wr, 1);
    drain("t1_drain");
    @(negedge clk);
    check("t1_idle_flit_wr", bus.flit_wr, 0);
    tick();

    // Router stall on cycles 4..6 holds the third flit.
    bus.pkt_in = 32'h0123_4567;
    bus.pkt_wr = 1'b1;
    sb_push_pkt(32'h0123_4567);
    tick();
    bus.pkt_wr = 1'b0;
    repeat (3) tick();
    bus.rt_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_flit_wr", bus.flit_wr, 0);
      check("stall_flit_out", bus.flit_out, 4'h2);
      tick();
    end
    bus.rt_full = 1'b0;
    drain("t2_drain");

    // Fill the FIFO behind a stalled packet; fifth push is dropped.
    bus.rt_full = 1'b1;
    bus.pkt_in  = 32'hA0A0_A0A0;
    bus.pkt_wr  = 1'b1;
    sb_push_pkt(32'hA0A0_A0A0);
    tick();
    bus.pkt_wr = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      bus.pkt_in = 32'h1234_5670 + i;
      bus.pkt_wr = 1'b1;
      if (i <= 4) sb_push_pkt(32'h1234_5670 + i);
      if (i == 4) begin
        @(negedge clk);
        check("full_after_3", bus.pkt_full, 0);
      end
      if (i == 5) begin
        @(negedge clk);
        check("full_after_4", bus.pkt_full, 1);
        check("drop_before", bus.pkt_drop, 0);
      end
      tick();
    end
    bus.pkt_wr = 1'b0;
    @(negedge clk);
    check("drop_pulse", bus.pkt_drop, 1);
    tick();
    @(negedge clk);
    check("drop_one_cycle", bus.pkt_drop, 0);
    check("full_held", bus.pkt_full, 1);
    tick();
    bus.rt_full = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.flit_wr) n++;
    end
    check("burst_no_gap", n, 40);
    @(negedge clk);
    check("burst_end_flit_wr", bus.flit_wr, 0);
    check("burst_end_full", bus.pkt_full, 0);
    check("burst_sb_empty", sb.size(), 0);
    tick();

    // RX decode: local packet, then misrouted packet.
    send_rx(32'h0000_0001, 1'b0);
    @(negedge clk);
    check("rx_local_misroute", bus.rx_misroute, 0);
    check("rx_spike_before_start", bus.spike, 0);
    pulse_start();
    @(negedge clk);
    check("rx_spike_axon1", bus.spike, 2'b10);
    tick();
    send_rx(32'h0300_0000, 1'b0);
    @(negedge clk);
    check("misroute_pulse", bus.rx_misroute, 1);
    tick();
    @(negedge clk);
    check("misroute_one_cycle", bus.rx_misroute, 0);
    pulse_start();
    @(negedge clk);
    check("misroute_no_spike", bus.spike, 0);
    tick();

    // Last flit coincides with start.
    send_rx(32'h0000_0000, 1'b0);
    send_rx(32'h0000_0001, 1'b1);
    @(negedge clk);
    check("boundary_old_step", bus.spike, 2'b01);
    pulse_start();
    @(negedge clk);
    check("boundary_new_step", bus.spike, 2'b10);
    tick();

    // Self-addressed TX packet.
    bus.pkt_in = 32'h0000_0000;
    bus.pkt_wr = 1'b1;
    sb_push_pkt(32'h0000_0000);
    tick();
    bus.pkt_wr = 1'b0;
`ifdef LOCAL_PACKET_BYPASS_EN
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.flit_wr) n++;
    end
    check("bypass_no_flits", n, 0);
    tick();
`else
    drain("self_drain");
    send_rx(32'h0000_0000, 1'b0);
`endif
    pulse_start();
    @(negedge clk);
    check("self_spike_axon0", bus.spike, 2'b01);
    tick();

    // Reset mid-packet on both RX and TX.
    for (int i = 0; i < 3; i++) begin
      bus.flit_in_wr = 1'b1;
      bus.flit_in    = 4'hF;
      tick();
    end
    bus.flit_in_wr = 1'b0;
    bus.flit_in    = '0;
    bus.pkt_in     = 32'h0102_0001;
    bus.pkt_wr     = 1'b1;
    sb_push_pkt(32'h0102_0001);
    tick();
    bus.pkt_wr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.flit_wr) n++;
    end
    check("post_reset_no_flits", n, 0);
    tick();
    send_rx(32'h0000_0001, 1'b0);
    @(negedge clk);
    check("post_reset_rx_misroute", bus.rx_misroute, 0);
    pulse_start();
    @(negedge clk);
    check("post_reset_rx_spike", bus.spike, 2'b10);

    check("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
